tt_um_plc_prg: RTL and testbench
================================

TT_UM_PLC_PRG -- requirements
Module: tt_um_plc_prg

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; clock port is named clk and reset port is named rst.
REQ-002 SHALL have the following ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- ena  input  1  design enable; always high in use and ignored by the logic.
- ui_in  input  8  [0]=START, [1]=AUTO, [2]=MAN, [7:3] unused.
- uo_out  output  8  [0]=CONTROL, [1]=TIMER_RUN, [2]=TIMER_DONE, [3]=AUTO_ACT, [4]=MAN_ACT, [5]=IDLE, [7:6]=0.
- uio_in  input  8  unused.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0 (all bidirectional pins are inputs).

Function
REQ-003 SHALL decode the mode each cycle as follows:
- MAN_ACT = MAN.
- AUTO_ACT = AUTO & !MAN; MAN has priority over AUTO.
- IDLE = !AUTO & !MAN.
REQ-004 SHALL contain an on-delay timer (TON) with a 32-bit cycle counter and a registered DONE flag.
REQ-005 SHALL advance the TON as follows:
- While AUTO_ACT & START, the counter increments by 1 per clock.
- When the counter reaches PRESET-1 and still increments, DONE sets on that edge.
- The counter then saturates at PRESET and never wraps.
REQ-006 SHALL clear the counter and DONE on the next clock edge whenever START=0 or AUTO_ACT=0 (release, mode change, or MAN override mid-timing).
REQ-007 SHALL make DONE assert after exactly PRESET consecutive rising edges sampled with AUTO_ACT & START high.
REQ-008 SHALL drive CONTROL as follows:
- MAN_ACT: CONTROL = START, combinational with zero clock latency.
- AUTO_ACT: CONTROL = START & DONE; it drops in the same cycle START falls.
- IDLE: CONTROL = 0 regardless of START.
REQ-009 SHALL drive TIMER_RUN = AUTO_ACT & START & !DONE and TIMER_DONE = DONE.
REQ-010 SHALL force all uo_out bits to 0 while rst=1, overriding the combinational paths.
REQ-011 SHALL treat inputs as already synchronous; no input synchronizers or debouncing, so that MAN response stays combinational.

Reset
REQ-012 SHALL, on a rising clk edge with rst=1, clear the counter to 0 and DONE to 0.
REQ-013 SHALL, if rst asserts mid-timing, abort the timing; after rst deasserts, timing restarts from 0 and needs a full PRESET cycles.
REQ-014 SHALL hold uo_out = 8'h00 during reset and output uio_out = uio_oe = 8'h00 at all times.

Configuration
REQ-015 SHALL select PRESET with the macro PLC_SHORT_TIMER_EN, which is the only compile-time option:
- Macro defined: PRESET = 20 cycles (simulation).
- Macro undefined: PRESET = 500_000_000 cycles (10 s at 50 MHz).

Verification
REQ-016 SHALL pass these directed scenarios, all with PLC_SHORT_TIMER_EN defined and a 20 ns clock:
- rst=1 for 3 cycles, ui_in=8'h07 -> uo_out=8'h00 throughout; counter 0 after release.
- AUTO=1, MAN=0, START=1 held 25 cycles -> CONTROL=0 and TIMER_RUN=1 for the first 19 edges; CONTROL=1 and TIMER_DONE=1 after the 20th edge. START=0 -> CONTROL=0 the same cycle, DONE clears on the next edge.
- AUTO=1, START pulsed high 10 cycles, low 1 cycle, high again -> CONTROL becomes 1 only 20 edges after the second rise.
- MAN=1, AUTO=0, START 0->1->0 -> CONTROL follows START within 1 ns; uo_out[4]=1.
- AUTO=1 and MAN=1, START=1 for 50 ns -> CONTROL=1 immediately (MAN priority); TIMER_RUN=0. Switch MAN to 0 mid-START -> the timer starts from 0.
- AUTO=0, MAN=0, START=1 for 100 ns -> CONTROL=0; IDLE=1.

Source files
------------

// File: rtl/tt_um_plc_prg.sv
// tt_um_plc_prg: PLC-style MAN/AUTO output control with an on-delay (TON) timer.
// Define PLC_SHORT_TIMER_EN for a 20-cycle preset; otherwise the preset is 10 s at 50 MHz.
module tt_um_plc_prg (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
`ifdef PLC_SHORT_TIMER_EN
  localparam logic [31:0] PRESET = 32'd20;
`else
  localparam logic [31:0] PRESET = 32'd500_000_000;
`endif
  logic [31:0] r_cnt;
  logic        r_done;
  logic        w_start, w_man, w_auto_act, w_idle, w_run_en, w_control, w_timer_run;
  logic        w_unused;
  assign w_start     = ui_in[0];
  assign w_man       = ui_in[2];
  assign w_auto_act  = ui_in[1] & ~ui_in[2];
  assign w_idle      = ~ui_in[1] & ~ui_in[2];
  assign w_run_en    = w_auto_act & w_start;
  assign w_unused    = &{1'b0, ena, uio_in, ui_in[7:3]};
  // The counter saturates at PRESET; DONE sets on the edge that takes it there.
  always_ff @(posedge clk) begin
    if (rst || !w_run_en) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (r_cnt != PRESET) begin
      r_cnt  <= r_cnt + 32'd1;
      r_done <= r_done | (r_cnt == PRESET - 32'd1);
    end
  end
  always_comb begin
    w_control   = w_man ? w_start : w_auto_act & w_start & r_done;
    w_timer_run = w_run_en & ~r_done;
    uo_out      = rst ? 8'h00 : {2'b00, w_idle, w_man, w_auto_act, r_done, w_timer_run, w_control};
  end
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_tt_um_plc_prg.sv
// tb_tt_um_plc_prg: directed checks of mode decode, TON timing, MAN priority and reset for tt_um_plc_prg.
module tb_tt_um_plc_prg;
`ifdef PLC_SHORT_TIMER_EN
  localparam int PRESET = 20;
`else
  localparam int PRESET = 500_000_000;
`endif
  localparam int LIM = (PRESET < 26) ? PRESET + 5 : 30;
  logic       clk = 1'b0, rst = 1'b1, ena = 1'b1;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int n_run = 0, n_fail = 0;
  typedef struct {
    logic       r;
    logic [7:0] ui;
    logic [7:0] exp;
    string      name;
  } vec_t;
  vec_t tbl[12];
  tt_um_plc_prg dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #10 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  // Holds AUTO+START from a cleared counter; DONE expected after exactly PRESET edges.
  task automatic timed(input string name, input int n);
    ui_in = 8'h03;
    for (int i = 1; i <= n; i++) begin
      tick();
      chk($sformatf("%s edge %0d", name, i), uo_out, (i >= PRESET) ? 8'h0D : 8'h0A);
    end
  endtask
  initial begin
    tbl[0]  = '{1'b1, 8'h07, 8'h00, "rst forces zero"};
    tbl[1]  = '{1'b0, 8'h04, 8'h10, "man start0"};
    tbl[2]  = '{1'b0, 8'h05, 8'h11, "man start1"};
    tbl[3]  = '{1'b0, 8'h06, 8'h10, "man+auto start0"};
    tbl[4]  = '{1'b0, 8'h07, 8'h11, "man+auto start1"};
    tbl[5]  = '{1'b0, 8'h00, 8'h20, "idle start0"};
    tbl[6]  = '{1'b0, 8'h01, 8'h20, "idle start1"};
    tbl[7]  = '{1'b0, 8'h02, 8'h08, "auto start0"};
    tbl[8]  = '{1'b0, 8'h03, 8'h0A, "auto start1"};
    tbl[9]  = '{1'b0, 8'hF9, 8'h20, "idle junk upper"};
    tbl[10] = '{1'b0, 8'hFD, 8'h11, "man junk upper"};
    tbl[11] = '{1'b1, 8'h05, 8'h00, "rst over man"};
    rst = 1'b1;
    ui_in = 8'h07;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset hold", uo_out, 8'h00);
    end
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].r;
      ui_in = tbl[i].ui;
      #1;
      chk(tbl[i].name, uo_out, tbl[i].exp);
      chk("uio_out", uio_out, 8'h00);
      chk("uio_oe", uio_oe, 8'h00);
      tick();
    end
    rst = 1'b0;
    ui_in = 8'h03;
    #1;
    chk("auto first cycle", uo_out, 8'h0A);
    timed("auto hold", LIM);
    ui_in = 8'h02;
    #1;
    chk("start drop same cycle", uo_out, (LIM >= PRESET) ? 8'h0C : 8'h08);
    tick();
    chk("done cleared", uo_out, 8'h08);
    ui_in = 8'h03;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("first pulse", uo_out, 8'h0A);
    end
    ui_in = 8'h02;
    tick();
    timed("restart", LIM);
    ui_in = 8'h02;
    tick();
    ui_in = 8'h04;
    #1;
    chk("man 0", uo_out, 8'h10);
    ui_in = 8'h05;
    #1;
    chk("man rise", uo_out, 8'h11);
    ui_in = 8'h04;
    #1;
    chk("man fall", uo_out, 8'h10);
    tick();
    ui_in = 8'h07;
    #1;
    chk("man priority", uo_out, 8'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("man priority hold", uo_out, 8'h11);
    end
    ui_in = 8'h03;
    #1;
    chk("man release", uo_out, 8'h0A);
    timed("after man", LIM);
    ui_in = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle hold", uo_out, 8'h20);
    end
    timed("pre rst", 15);
    rst = 1'b1;
    #1;
    chk("rst mid timing", uo_out, 8'h00);
    tick();
    chk("rst edge", uo_out, 8'h00);
    rst = 1'b0;
    #1;
    chk("rst release", uo_out, 8'h0A);
    timed("post rst", LIM);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
